if_fetch_unit: RTL and testbench

//  Instruction-fetch front end of the 5-stage 16-bit pipeline.
//  - Owns the architectural PC: generates sequential or redirect targets and drives the imem request handshake.
//  - Delivers {instr, pc} pairs to the IF/ID boundary with a valid/ready handshake.
//  - Absorbs decode back-pressure and EX-stage branch/jump redirects without losing or duplicating instructions.

---
 rtl/if_fetch_unit_pkg.sv | 34 +++
 rtl/if_fetch_unit_if.sv | 29 ++
 rtl/if_fetch_unit_skid.sv | 40 ++++
 rtl/if_fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Holds the FSM state encoding, the {instr, pc} pair type, the PC width
// used by everything that handles program counters, and small helpers.
package if_fetch_unit_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_pair_t;

    // PC arithmetic wraps silently modulo 2^PC_W
    function automatic logic [PC_W-1:0] pc_advance(input logic [PC_W-1:0] pc,
                                                   input logic [PC_W-1:0] step);
        return pc + step;
    endfunction

    // Saturating increment for 16-bit event counters
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory, decode and EX.
// master = fetch unit side, slave = environment (imem/decode/EX) side.
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;
    logic               id_ready;

    logic               redir_valid;
    logic [PC_W-1:0]    redir_pc;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_ack, imem_rdata, id_ready, redir_valid, redir_pc
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_ack, imem_rdata, id_ready, redir_valid, redir_pc
    );

endinterface

// File: rtl/if_fetch_unit_skid.sv
// fetch_skid_buf: one-entry {instr, pc} buffer with valid/ready on both
// sides. Catches a word returned by imem while the IF/ID slot is still
// occupied, so the fetch unit never has to refuse a completed read.
module fetch_skid_buf
    import if_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  fetch_pair_t in_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output fetch_pair_t out_data_o
);

    logic        valid_q;
    fetch_pair_t data_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Entry fills on an accepted push, empties on a pop or a flush
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
        end else if (out_ready_i && valid_q) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch front end of the 16-bit 5-stage pipe.
// Owns the PC, runs the imem request handshake, and presents {instr, pc}
// to decode with valid/ready. EX redirects flush everything in flight.
// Optional build macro IF_FETCH_PERF_EN adds saturating perf counters
// perf_fetched (words accepted by decode) and perf_killed (imem responses
// discarded because of a redirect).
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = 16'h0000,
    parameter logic [PC_W-1:0]    PC_STEP   = 16'd1,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            clr,
    if_fetch_unit_if.master bus
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [15:0]     perf_fetched,
    output logic [15:0]     perf_killed
`endif
);

    fetch_state_e    state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] imem_addr_q;
    logic            imem_req_q;
    logic            slot_valid_q;
    fetch_pair_t     slot_q;

    logic [PC_W-1:0] pc_step_d;
    logic            imem_ack_w;
    logic            redir;
    logic            transfer;
    logic            slot_free;
    logic            skid_push;
    logic            skid_pop;
    logic            skid_in_ready;
    logic            skid_valid;
    fetch_pair_t     skid_data;
    fetch_pair_t     fetched;

    // A redirect is ignored only in the single IDLE cycle after reset
    assign imem_ack_w = bus.imem_ack;
    assign redir      = bus.redir_valid && (state_q != S_IDLE);
    assign transfer   = slot_valid_q && bus.id_ready;
    assign slot_free  = !slot_valid_q || bus.id_ready;
    assign pc_step_d  = pc_advance(pc_q, PC_STEP);
    assign fetched    = '{instr: bus.imem_rdata, pc: imem_addr_q};

    // Returned word goes to the skid only when decode is stalled
    assign skid_push = (state_q == S_REQ) && imem_ack_w && !slot_free
                       && !redir && skid_in_ready;
    assign skid_pop  = (state_q == S_HOLD) && skid_valid && slot_free && !redir;

    fetch_skid_buf u_skid (
        .clk         (clk),
        .clr         (clr),
        .flush_i     (redir),
        .in_valid_i  (skid_push),
        .in_ready_o  (skid_in_ready),
        .in_data_i   (fetched),
        .out_valid_o (skid_valid),
        .out_ready_i (skid_pop),
        .out_data_o  (skid_data)
    );

    // Fetch FSM: PC, imem request/address, and the IF/ID output slot
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= RESET_PC;
            slot_valid_q <= 1'b0;
            slot_q       <= '{instr: NOP_INSTR, pc: '0};
        end else if (redir) begin
            // Redirect wins over everything; a transfer in this same cycle
            // has already been taken by decode, so the slot just empties.
            pc_q         <= bus.redir_pc;
            slot_valid_q <= 1'b0;
            if ((state_q == S_REQ || state_q == S_DRAIN) && !imem_ack_w) begin
                // Read still outstanding: keep req/addr until it completes
                state_q <= S_DRAIN;
            end else begin
                // Nothing outstanding (or the read completes now and is
                // dropped): start fetching the target immediately
                state_q     <= S_REQ;
                imem_req_q  <= 1'b1;
                imem_addr_q <= bus.redir_pc;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q     <= S_REQ;
                    imem_req_q  <= 1'b1;
                    imem_addr_q <= pc_q;
                end
                S_REQ: begin
                    if (imem_ack_w && slot_free) begin
                        slot_valid_q <= 1'b1;
                        slot_q       <= fetched;
                        pc_q         <= pc_step_d;
                        imem_addr_q  <= pc_step_d;
                    end else if (skid_push) begin
                        pc_q        <= pc_step_d;
                        imem_addr_q <= pc_step_d;
                        imem_req_q  <= 1'b0;
                        state_q     <= S_HOLD;
                    end else if (transfer) begin
                        slot_valid_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (skid_pop) begin
                        slot_valid_q <= 1'b1;
                        slot_q       <= skid_data;
                        state_q      <= S_REQ;
                        imem_req_q   <= 1'b1;
                        imem_addr_q  <= pc_q;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack_w) begin
                        state_q     <= S_REQ;
                        imem_addr_q <= pc_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = imem_addr_q;
    assign bus.if_valid  = slot_valid_q;
    assign bus.if_instr  = slot_valid_q ? slot_q.instr : NOP_INSTR;
    assign bus.if_pc     = slot_q.pc;

`ifdef IF_FETCH_PERF_EN
    logic [15:0] perf_fetched_q;
    logic [15:0] perf_killed_q;
    logic        kill_event;

    assign kill_event = imem_ack_w
                        && ((state_q == S_DRAIN) || (state_q == S_REQ && redir));

    // Saturating counters of delivered words and discarded imem responses
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            perf_fetched_q <= '0;
            perf_killed_q  <= '0;
        end else begin
            if (transfer) begin
                perf_fetched_q <= sat_inc(perf_fetched_q);
            end
            if (kill_event) begin
                perf_killed_q <= sat_inc(perf_killed_q);
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_killed  = perf_killed_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed vector table, wrap-around and
// async-clear sequences, then randomized imem latency / back-pressure /
// redirects checked against an in-order delivery model.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic clr0;
    logic clr1;

    always #5 clk = ~clk;

    if_fetch_unit_if bus0 ();
    if_fetch_unit_if bus1 ();

`ifdef IF_FETCH_PERF_EN
    logic [15:0] perfFetched0, perfKilled0, perfFetched1, perfKilled1;
`endif

    if_fetch_unit dut0 (
        .clk (clk),
        .clr (clr0),
        .bus (bus0)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetched (perfFetched0),
        .perf_killed  (perfKilled0)
`endif
    );

    if_fetch_unit #(.RESET_PC(16'hFFFE)) dut1 (
        .clk (clk),
        .clr (clr1),
        .bus (bus1)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetched (perfFetched1),
        .perf_killed  (perfKilled1)
`endif
    );

    typedef struct {
        logic        ack;
        logic        rdy;
        logic        redir;
        logic [15:0] rpc;
        logic        eReq;
        logic [15:0] eAddr;
        logic        eValid;
        logic [15:0] ePc;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    int testsRun = 0;
    int testsFailed = 0;

    // Random-phase scratch state
    logic        rRdy, rAck, rRedir, prevWait, mustEmpty;
    logic [15:0] rRpc, prevAddr, expPc, expA, expD;
    int          lat, delivered, seen;

    // Instruction memory contents: a fixed scramble of the address
    function automatic logic [15:0] memWord(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    function automatic vec_t mkVec(input logic ack, input logic rdy, input logic redir,
                                   input logic [15:0] rpc, input logic eReq,
                                   input logic [15:0] eAddr, input logic eValid,
                                   input logic [15:0] ePc);
        vec_t v;
        v.ack = ack; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid; v.ePc = ePc;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] got,
                               input logic [15:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic ack, input logic rdy, input logic redir,
                                 input logic [15:0] rpc);
        bus0.imem_ack    = ack;
        bus0.imem_rdata  = ack ? memWord(bus0.imem_addr) : 16'hBAD0;
        bus0.id_ready    = rdy;
        bus0.redir_valid = redir;
        bus0.redir_pc    = rpc;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Cycle-by-cycle expectations starting in the IDLE cycle after clear
        vecs[0]  = mkVec(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        vecs[1]  = mkVec(1, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000);
        vecs[2]  = mkVec(1, 1, 0, 16'h0000, 1, 16'h0001, 1, 16'h0000);
        vecs[3]  = mkVec(1, 1, 0, 16'h0000, 1, 16'h0002, 1, 16'h0001);
        vecs[4]  = mkVec(1, 0, 0, 16'h0000, 1, 16'h0003, 1, 16'h0002);
        vecs[5]  = mkVec(0, 0, 0, 16'h0000, 0, 16'h0004, 1, 16'h0002);
        vecs[6]  = mkVec(0, 0, 0, 16'h0000, 0, 16'h0004, 1, 16'h0002);
        vecs[7]  = mkVec(0, 1, 0, 16'h0000, 0, 16'h0004, 1, 16'h0002);
        vecs[8]  = mkVec(0, 1, 1, 16'h0040, 1, 16'h0004, 1, 16'h0003);
        vecs[9]  = mkVec(0, 1, 0, 16'h0000, 1, 16'h0004, 0, 16'h0000);
        vecs[10] = mkVec(0, 1, 0, 16'h0000, 1, 16'h0004, 0, 16'h0000);
        vecs[11] = mkVec(1, 1, 0, 16'h0000, 1, 16'h0004, 0, 16'h0000);
        vecs[12] = mkVec(0, 1, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000);
        vecs[13] = mkVec(1, 1, 1, 16'h0100, 1, 16'h0040, 0, 16'h0000);
        vecs[14] = mkVec(1, 1, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000);
        vecs[15] = mkVec(0, 1, 0, 16'h0000, 1, 16'h0101, 1, 16'h0100);
        vecs[16] = mkVec(0, 1, 0, 16'h0000, 1, 16'h0101, 0, 16'h0000);

        clr0 = 1'b1;
        clr1 = 1'b1;
        applyStimulus(0, 0, 0, 16'h0000);
        bus1.imem_ack = 1'b0; bus1.imem_rdata = 16'h0000; bus1.id_ready = 1'b0;
        bus1.redir_valid = 1'b0; bus1.redir_pc = 16'h0000;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req",   16'(bus0.imem_req), 16'h0);
        checkOutput("rst_addr",  bus0.imem_addr, 16'h0000);
        checkOutput("rst_valid", 16'(bus0.if_valid), 16'h0);
        checkOutput("rst_instr", bus0.if_instr, NOP_INSTR_DEFAULT);
        checkOutput("rst_pc",    bus0.if_pc, 16'h0000);
        checkOutput("rst_addr_fffe", bus1.imem_addr, 16'hFFFE);

        // Directed table: streaming, stall into skid, drain-redirect, ack-redirect
        clr0 = 1'b0;
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].ack, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
            @(negedge clk);
            checkOutput($sformatf("v%0d_req", i),   16'(bus0.imem_req), 16'(vecs[i].eReq));
            checkOutput($sformatf("v%0d_addr", i),  bus0.imem_addr, vecs[i].eAddr);
            checkOutput($sformatf("v%0d_valid", i), 16'(bus0.if_valid), 16'(vecs[i].eValid));
            checkOutput($sformatf("v%0d_instr", i), bus0.if_instr,
                        vecs[i].eValid ? memWord(vecs[i].ePc) : NOP_INSTR_DEFAULT);
            if (vecs[i].eValid)
                checkOutput($sformatf("v%0d_pc", i), bus0.if_pc, vecs[i].ePc);
            nextCycle();
        end

        // Async clear while a request waits and the slot is full
        applyStimulus(1, 0, 0, 16'h0000);
        nextCycle();
        applyStimulus(0, 0, 0, 16'h0000);
        @(negedge clk);
        checkOutput("preclr_req",   16'(bus0.imem_req), 16'h1);
        checkOutput("preclr_valid", 16'(bus0.if_valid), 16'h1);
        checkOutput("preclr_pc",    bus0.if_pc, 16'h0101);
        #2;
        clr0 = 1'b1;
        #1;
        checkOutput("clr_async_req",   16'(bus0.imem_req), 16'h0);
        checkOutput("clr_async_valid", 16'(bus0.if_valid), 16'h0);
        checkOutput("clr_async_addr",  bus0.imem_addr, 16'h0000);
        checkOutput("clr_async_instr", bus0.if_instr, NOP_INSTR_DEFAULT);
        nextCycle();
        clr0 = 1'b0;
        @(negedge clk);
        checkOutput("restart_idle_req", 16'(bus0.imem_req), 16'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("restart_req",  16'(bus0.imem_req), 16'h1);
        checkOutput("restart_addr", bus0.imem_addr, 16'h0000);

        // PC wrap-around on the RESET_PC=FFFE instance, zero-wait imem
        nextCycle();
        clr1 = 1'b0;
        bus1.id_ready = 1'b1;
        expA = 16'hFFFE;
        expD = 16'hFFFE;
        seen = 0;
        for (int c = 0; c < 10 && seen < 4; c++) begin
            bus1.imem_ack   = bus1.imem_req;
            bus1.imem_rdata = memWord(bus1.imem_addr);
            @(negedge clk);
            if (bus1.imem_req) begin
                checkOutput($sformatf("wrap_addr%0d", seen), bus1.imem_addr, expA);
                expA = expA + 16'd1;
                seen++;
            end
            if (bus1.if_valid) begin
                checkOutput("wrap_pc", bus1.if_pc, expD);
                checkOutput("wrap_instr", bus1.if_instr, memWord(expD));
                expD = expD + 16'd1;
            end
            nextCycle();
        end
        bus1.imem_ack = 1'b0;
        if (seen < 4) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL wrap_timeout: got %0d requests, expected 4", seen);
        end

        // Randomized run against the in-order delivery model
        clr0 = 1'b1;
        applyStimulus(0, 0, 0, 16'h0000);
        nextCycle();
        clr0 = 1'b0;
        expPc = 16'h0000;
        lat = -1;
        prevWait = 1'b0;
        prevAddr = 16'h0000;
        mustEmpty = 1'b0;
        delivered = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (prevWait) begin
                checkOutput("hold_req",  16'(bus0.imem_req), 16'h1);
                checkOutput("hold_addr", bus0.imem_addr, prevAddr);
            end
            rRdy = ($urandom_range(0, 3) != 0);
            rAck = 1'b0;
            if (bus0.imem_req) begin
                if (lat < 0) lat = $urandom_range(0, 2);
                if (lat == 0) begin
                    rAck = 1'b1;
                    lat = -1;
                end else begin
                    lat--;
                end
            end else begin
                lat = -1;
            end
            rRedir = (cyc > 3) && ($urandom_range(0, 24) == 0);
            rRpc = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'hFFFD;
            applyStimulus(rAck, rRdy, rRedir, rRpc);
            prevWait = bus0.imem_req && !rAck;
            prevAddr = bus0.imem_addr;
            @(negedge clk);
            if (mustEmpty)
                checkOutput("redir_flush", 16'(bus0.if_valid), 16'h0);
            if (!bus0.if_valid) begin
                checkOutput("idle_nop", bus0.if_instr, NOP_INSTR_DEFAULT);
            end else if (rRdy) begin
                checkOutput("rnd_pc",    bus0.if_pc, expPc);
                checkOutput("rnd_instr", bus0.if_instr, memWord(expPc));
                expPc = expPc + 16'd1;
                delivered++;
            end
            if (rRedir) expPc = rRpc;
            mustEmpty = rRedir;
            nextCycle();
        end
        testsRun++;
        if (delivered < 300) begin
            testsFailed++;
            $display("[TB] FAIL rnd_progress: got %0d deliveries, expected at least 300", delivered);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
